// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between the multicycle controller and its datapath
//
// Purpose: groups everything the controller exchanges with the datapath.
//   master : the controller (drives selects/enables, reads opcode/zero/mem_ready)
//   slave  : the datapath side (drives opcode/zero/mem_ready, reads the selects)
// Signals:
//   opcode[5:0], zero, mem_ready                      datapath -> controller
//   mem_req, iord, memwrite, irwrite, pcwrite,
//   regdst, memtoreg, regwrite, alusrca,
//   alusrcb[1:0], aluop[1:0], pcsrc[1:0],
//   instr_done, illegal_op, state_o[3:0]              controller -> datapath
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, instr_done, illegal_op, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, instr_done, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM sequencing a shared-memory multicycle MIPS datapath
//
// Purpose: steps R-type, lw, sw, beq, addi and j through FETCH/DECODE/execute/writeback,
//   emitting per-state datapath selects and write enables. Memory states stall on mem_ready.
// Parameters:
//   ILLEGAL_TRAP  0: unknown opcode returns to FETCH, 1: parks in TRAP until reset
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (forces IDLE, all outputs 0)
//   bus  multicycle_ctrl_if.master (opcode/zero/mem_ready in, selects/enables/status out)
module multicycle_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Registered per-state controls. Enables that also depend on mem_ready/zero
  // are stored as qualifiers and combined with the live input at the output.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       irw_on_ready;   // FETCH: IR load when memory completes
    logic       pcw_on_ready;   // FETCH: PC+4 when memory completes
    logic       pcw_on_zero;    // BRANCH: PC load when operands equal
    logic       pcw_always;     // JUMP
    logic       done;           // unconditional last-state pulse
    logic       done_on_ready;  // MEMWR: last state ends on mem_ready
    logic       in_decode;
  } ctl_t;

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;
  logic   op_known;

  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req      = 1'b1;
        c.alusrcb      = 2'b01;
        c.irw_on_ready = 1'b1;
        c.pcw_on_ready = 1'b1;
      end
      S_DECODE: begin
        c.alusrcb   = 2'b11;
        c.in_decode = 1'b1;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.done     = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req       = 1'b1;
        c.iord          = 1'b1;
        c.memwrite      = 1'b1;
        c.done_on_ready = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        c.done     = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcsrc       = 2'b01;
        c.pcw_on_zero = 1'b1;
        c.done        = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        c.done     = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc      = 2'b10;
        c.pcw_always = 1'b1;
        c.done       = 1'b1;
      end
      default: c = '0;  // IDLE, TRAP
    endcase
    return c;
  endfunction

  always_comb begin
    op_known = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW)   ||
               (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ)  ||
               (bus.opcode == OP_ADDI)  || (bus.opcode == OP_J);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      // IR holds the opcode, so only the lw/sw distinction matters here.
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;  // unused codes recover
    endcase
    ctl_d = ctl_for(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.mem_req    = ctl_q.mem_req;
  assign bus.iord       = ctl_q.iord;
  assign bus.memwrite   = ctl_q.memwrite;
  assign bus.regdst     = ctl_q.regdst;
  assign bus.memtoreg   = ctl_q.memtoreg;
  assign bus.regwrite   = ctl_q.regwrite;
  assign bus.alusrca    = ctl_q.alusrca;
  assign bus.alusrcb    = ctl_q.alusrcb;
  assign bus.aluop      = ctl_q.aluop;
  assign bus.pcsrc      = ctl_q.pcsrc;
  assign bus.irwrite    = ctl_q.irw_on_ready & bus.mem_ready;
  assign bus.pcwrite    = (ctl_q.pcw_on_ready & bus.mem_ready) |
                          (ctl_q.pcw_on_zero & bus.zero) |
                          ctl_q.pcw_always;
  assign bus.instr_done = ctl_q.done | (ctl_q.done_on_ready & bus.mem_ready);
  assign bus.illegal_op = ctl_q.in_decode & ~op_known;
  assign bus.state_o    = state_q;

endmodule
